// File: rtl/clock_pkg.sv
// ---------------------------------------------------------------------------
// clock_pkg
// Shared constants for the VGA clock time keeper: BCD field widths, digit
// limits and the default prescaler ratio for the pixel clock. Also holds a
// helper that sizes the prescaler.
// ---------------------------------------------------------------------------
package clock_pkg;

    // Widths of the six BCD digit fields
    localparam int SEC_U_W = 4;
    localparam int SEC_D_W = 3;
    localparam int MIN_U_W = 4;
    localparam int MIN_D_W = 3;
    localparam int HRS_U_W = 4;
    localparam int HRS_D_W = 2;

    // Highest legal tens digit for minutes/seconds, highest 24-hour value
    localparam int MAX_TENS_MS = 5;
    localparam int MAX_HRS_24  = 23;

    // 31.5 MHz pixel clock (640x480 @ 72 Hz)
    localparam int DEFAULT_TICKS_PER_SEC = 31_500_000;

    // A ratio of 1 would give a zero-width counter; keep at least one bit.
    function automatic int presc_width(input int ticks);
        return (ticks > 1) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/bcd_field.sv
// ---------------------------------------------------------------------------
// bcd_field
// Two-digit BCD modulo counter used for the seconds, minutes and hours
// fields of the time keeper.
//
// Parameters:
//   UNITS_W, TENS_W  digit widths
//   MODULUS          field counts 00..MODULUS-1 (ignored when TWELVE_HOUR=1)
//   TWELVE_HOUR      1 = 12-hour sequence 12, 01 .. 11, 12 with reset at 12
//
// Ports:
//   px_clk      in   rising-edge clock
//   reset       in   synchronous, active-high; loads 00 (or 12 in 12-hour)
//   inc         in   advance the field by one this cycle
//   carry_src   in   the increment comes from the carry chain (not an adjust)
//   units       out  units digit
//   tens        out  tens digit
//   wrap_carry  out  combinational; field wraps this cycle due to carry_src
// ---------------------------------------------------------------------------
module bcd_field
    import clock_pkg::*;
#(
    parameter int UNITS_W     = SEC_U_W,
    parameter int TENS_W      = SEC_D_W,
    parameter int MODULUS     = (MAX_TENS_MS + 1) * 10,
    parameter bit TWELVE_HOUR = 1'b0
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic               inc,
    input  logic               carry_src,
    output logic [UNITS_W-1:0] units,
    output logic [TENS_W-1:0]  tens,
    output logic               wrap_carry
);

    // The 12-hour field tops out at 12 and restarts at 01 rather than 00.
    localparam int TOP_VAL   = TWELVE_HOUR ? 12 : MODULUS - 1;
    localparam int WRAP_VAL  = TWELVE_HOUR ? 1  : 0;
    localparam int RESET_VAL = TWELVE_HOUR ? 12 : 0;

    localparam logic [UNITS_W-1:0] TOP_U   = UNITS_W'(TOP_VAL % 10);
    localparam logic [TENS_W-1:0]  TOP_T   = TENS_W'(TOP_VAL / 10);
    localparam logic [UNITS_W-1:0] WRAP_U  = UNITS_W'(WRAP_VAL % 10);
    localparam logic [TENS_W-1:0]  WRAP_T  = TENS_W'(WRAP_VAL / 10);
    localparam logic [UNITS_W-1:0] RESET_U = UNITS_W'(RESET_VAL % 10);
    localparam logic [TENS_W-1:0]  RESET_T = TENS_W'(RESET_VAL / 10);
    localparam logic [UNITS_W-1:0] NINE    = UNITS_W'(9);

    logic at_top;

    assign at_top     = (units == TOP_U) && (tens == TOP_T);
    // Only carry-driven wraps ripple upward; adjust pulses stay local.
    assign wrap_carry = inc && carry_src && at_top;

    // BCD increment: wrap at the top value, otherwise units 9 rolls into tens.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            units <= RESET_U;
            tens  <= RESET_T;
        end else if (inc) begin
            if (at_top) begin
                units <= WRAP_U;
                tens  <= WRAP_T;
            end else if (units == NINE) begin
                units <= '0;
                tens  <= tens + TENS_W'(1);
            end else begin
                units <= units + UNITS_W'(1);
            end
        end
    end

endmodule

// File: rtl/bcd_time_counter.sv
// ---------------------------------------------------------------------------
// bcd_time_counter
// Time-of-day keeper for the VGA clock. Divides px_clk to a 1 Hz tick and
// keeps hh:mm:ss as six BCD digits feeding the digit/font render path.
//
// Build option: define TWELVE_HOUR_EN for 12-hour display (12, 01 .. 11,
// reset to 12:00:00). Undefined gives 24-hour time resetting to 00:00:00.
//
// Parameters:
//   TICKS_PER_SEC  px_clk cycles per second
//
// Ports:
//   px_clk         in   pixel clock, all state on rising edge
//   reset          in   synchronous, active-high; overrides everything
//   run            in   1 = prescaler counts, 0 = time frozen
//   adj_sec_pulse  in   seconds +1 without carry
//   adj_min_pulse  in   minutes +1 without carry
//   adj_hrs_pulse  in   hours +1
//   sec_u/sec_d    out  seconds digits
//   min_u/min_d    out  minutes digits
//   hrs_u/hrs_d    out  hours digits
//   sec_tick       out  high in the cycle a tick-driven update becomes visible
// ---------------------------------------------------------------------------
module bcd_time_counter
    import clock_pkg::*;
#(
    parameter int TICKS_PER_SEC = DEFAULT_TICKS_PER_SEC
) (
    input  logic               px_clk,
    input  logic               reset,
    input  logic               run,
    input  logic               adj_sec_pulse,
    input  logic               adj_min_pulse,
    input  logic               adj_hrs_pulse,
    output logic [SEC_U_W-1:0] sec_u,
    output logic [SEC_D_W-1:0] sec_d,
    output logic [MIN_U_W-1:0] min_u,
    output logic [MIN_D_W-1:0] min_d,
    output logic [HRS_U_W-1:0] hrs_u,
    output logic [HRS_D_W-1:0] hrs_d,
    output logic               sec_tick
);

    localparam int                 PRESC_W    = presc_width(TICKS_PER_SEC);
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);
    localparam int                 MS_MOD     = (MAX_TENS_MS + 1) * 10;
    localparam int                 HRS_MOD    = MAX_HRS_24 + 1;

`ifdef TWELVE_HOUR_EN
    localparam bit TWELVE_HOUR = 1'b1;
`else
    localparam bit TWELVE_HOUR = 1'b0;
`endif

    logic [PRESC_W-1:0] presc;
    logic               tick;
    logic               sec_carry;
    logic               min_carry;

    assign tick = run && (presc == PRESC_LAST);

    // Prescaler holds while stopped; adjust pulses never disturb it.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            presc <= '0;
        end else if (run) begin
            presc <= tick ? '0 : presc + PRESC_W'(1);
        end
    end

    // Registered so it lines up with the digits the tick just updated.
    always_ff @(posedge px_clk) begin
        if (reset) begin
            sec_tick <= 1'b0;
        end else begin
            sec_tick <= tick;
        end
    end

    bcd_field #(
        .UNITS_W    (SEC_U_W),
        .TENS_W     (SEC_D_W),
        .MODULUS    (MS_MOD),
        .TWELVE_HOUR(1'b0)
    ) u_sec (
        .px_clk    (px_clk),
        .reset     (reset),
        .inc       (tick || adj_sec_pulse),
        .carry_src (tick),
        .units     (sec_u),
        .tens      (sec_d),
        .wrap_carry(sec_carry)
    );

    bcd_field #(
        .UNITS_W    (MIN_U_W),
        .TENS_W     (MIN_D_W),
        .MODULUS    (MS_MOD),
        .TWELVE_HOUR(1'b0)
    ) u_min (
        .px_clk    (px_clk),
        .reset     (reset),
        .inc       (sec_carry || adj_min_pulse),
        .carry_src (sec_carry),
        .units     (min_u),
        .tens      (min_d),
        .wrap_carry(min_carry)
    );

    // Day rollover has no consumer, so the hours carry is left open.
    bcd_field #(
        .UNITS_W    (HRS_U_W),
        .TENS_W     (HRS_D_W),
        .MODULUS    (HRS_MOD),
        .TWELVE_HOUR(TWELVE_HOUR)
    ) u_hrs (
        .px_clk    (px_clk),
        .reset     (reset),
        .inc       (min_carry || adj_hrs_pulse),
        .carry_src (min_carry),
        .units     (hrs_u),
        .tens      (hrs_d),
        .wrap_carry()
    );

endmodule
